// File: rtl/elevator_call_scheduler_pkg.sv
// Shared types and constants for the elevator call scheduler: floor codes,
// FSM state encoding and the floor-to-request one-hot helper.
package elevator_pkg;

    localparam int N_FLOORS    = 4;
    localparam int FLOOR_W     = 2;
    localparam int DOOR_CYCLES = 8;

    typedef logic [FLOOR_W-1:0]  floor_t;
    typedef logic [N_FLOORS-1:0] floor_vec_t;

    localparam floor_t FL_G = 2'd0;
    localparam floor_t FL_1 = 2'd1;
    localparam floor_t FL_2 = 2'd2;
    localparam floor_t FL_3 = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOVE = 2'd1,
        ST_DOOR = 2'd2
    } state_t;

    function automatic floor_vec_t onehot(floor_t f);
        return floor_vec_t'(1) << f;
    endfunction

endpackage

// File: rtl/elevator_call_scheduler_if.sv
// Call-panel / car-FSM side signals of the scheduler. The scheduler is the
// slave; whatever drives buttons and reports the car floor is the master.
interface elevator_call_scheduler_if;
    import elevator_pkg::*;

    floor_vec_t btn;
    floor_t     floor;
    logic       req_g;
    logic       req_f1;
    logic       req_f2;
    logic       req_f3;
    floor_vec_t pending;
    logic       door_open;
    logic       dir_up;
    logic       busy;

    modport master (
        output btn, floor,
        input  req_g, req_f1, req_f2, req_f3, pending, door_open, dir_up, busy
    );

    modport slave (
        input  btn, floor,
        output req_g, req_f1, req_f2, req_f3, pending, door_open, dir_up, busy
    );

endinterface

// File: rtl/elevator_scan_picker.sv
// Combinational SCAN target selection: current floor first, then the nearest
// call in the sweep direction, otherwise reverse and take the nearest behind.
module elevator_scan_picker
    import elevator_pkg::*;
(
    input  floor_vec_t pending,
    input  floor_t     floor,
    input  logic       dir_up,
    output logic       valid,
    output floor_t     target,
    output logic       new_dir
);

    logic   found_above;
    logic   found_below;
    floor_t lowest_above;
    floor_t highest_below;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; that is what keeps synthesis from inferring latches.
    always_comb begin
        found_above   = 1'b0;
        found_below   = 1'b0;
        lowest_above  = floor;
        highest_below = floor;
        for (int i = N_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && i > int'(floor)) begin
                found_above  = 1'b1;
                lowest_above = floor_t'(i);
            end
        end
        for (int i = 0; i < N_FLOORS; i++) begin
            if (pending[i] && i < int'(floor)) begin
                found_below   = 1'b1;
                highest_below = floor_t'(i);
            end
        end
    end

    always_comb begin
        valid   = |pending;
        target  = floor;
        new_dir = dir_up;
        if (pending[floor]) begin
            target = floor;
        end else if (dir_up) begin
            if (found_above) begin
                target = lowest_above;
            end else begin
                target  = highest_below;
                new_dir = 1'b0;
            end
        end else begin
            if (found_below) begin
                target = highest_below;
            end else begin
                target  = lowest_above;
                new_dir = 1'b1;
            end
        end
    end

endmodule

// File: rtl/elevator_call_scheduler.sv
// Latches floor calls, serves them in SCAN order through one-hot requests to
// the car FSM, and holds the door open for a fixed dwell at each stop.
module elevator_call_scheduler
    import elevator_pkg::*;
#(
    parameter int DOOR_CYCLES_P = DOOR_CYCLES
) (
    input  logic                      clk,
    input  logic                      rst_n,
    elevator_call_scheduler_if.slave  bus
);

    localparam int               CNT_W    = $clog2(DOOR_CYCLES_P);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DOOR_CYCLES_P - 1);

    state_t           state;
    floor_vec_t       pending;
    floor_vec_t       clr;
    floor_vec_t       req;
    floor_t           target;
    logic [CNT_W-1:0] count;
    logic             door_open;
    logic             dir_up;
    logic             busy;

    logic   pick_valid;
    floor_t pick_target;
    logic   pick_dir;

    elevator_scan_picker u_picker (
        .pending (pending),
        .floor   (bus.floor),
        .dir_up  (dir_up),
        .valid   (pick_valid),
        .target  (pick_target),
        .new_dir (pick_dir)
    );

    // Bits served this cycle; clearing beats a simultaneous button press.
    always_comb begin
        clr = '0;
        case (state)
            ST_IDLE: if (pick_valid && pick_target == bus.floor) clr = onehot(bus.floor);
            ST_MOVE: if (bus.floor == target) clr = onehot(target);
            ST_DOOR: clr = bus.btn & onehot(bus.floor);
            default: clr = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= '0;
        else        pending <= (pending | bus.btn) & ~clr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            req       <= '0;
            target    <= FL_G;
            count     <= '0;
            door_open <= 1'b0;
            dir_up    <= 1'b1;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        target <= pick_target;
                        dir_up <= pick_dir;
                        busy   <= 1'b1;
                        if (pick_target == bus.floor) begin
                            state     <= ST_DOOR;
                            door_open <= 1'b1;
                            count     <= CNT_LOAD;
                        end else begin
                            state <= ST_MOVE;
                            req   <= onehot(pick_target);
                        end
                    end
                end
                ST_MOVE: begin
                    // Transit floors are ignored; only arrival at the frozen target counts.
                    if (bus.floor == target) begin
                        state     <= ST_DOOR;
                        req       <= '0;
                        door_open <= 1'b1;
                        count     <= CNT_LOAD;
                    end
                end
                ST_DOOR: begin
                    if (bus.btn[bus.floor]) begin
                        count <= CNT_LOAD;
                    end else if (count == '0) begin
                        state     <= ST_IDLE;
                        door_open <= 1'b0;
                        busy      <= 1'b0;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    req       <= '0;
                    door_open <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_g     = req[FL_G];
    assign bus.req_f1    = req[FL_1];
    assign bus.req_f2    = req[FL_2];
    assign bus.req_f3    = req[FL_3];
    assign bus.pending   = pending;
    assign bus.door_open = door_open;
    assign bus.dir_up    = dir_up;
    assign bus.busy      = busy;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Bench for elevator_call_scheduler: a table of multi-stop SCAN scenarios with
// a scoreboard of expected stop floors, plus hand sequences for the corner cases.
module tb_elevator_call_scheduler;
    import elevator_pkg::*;

    logic clk;
    logic rst_n;

    elevator_call_scheduler_if bus ();

    elevator_call_scheduler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        floor_t     start;
        floor_vec_t btn;
        int         n_stops;
        floor_t     s0;
        floor_t     s1;
        floor_t     s2;
        logic       dir;
    } vec_t;

    vec_t   vecs [7];
    floor_t exp_q [$];

    int     n_checks;
    int     n_pass;
    logic   car_en;
    floor_t car_next;
    logic   prev_door;
    int     dwell;
    int     exp_dwell;
    logic   saw_req;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic floor_vec_t req_vec();
        return {bus.req_f3, bus.req_f2, bus.req_f1, bus.req_g};
    endfunction

    function automatic floor_t decode(input floor_vec_t r);
        floor_t f = FL_G;
        for (int i = 0; i < N_FLOORS; i++) if (r[i]) f = floor_t'(i);
        return f;
    endfunction

    // One clock: car model steps to the requested floor one cycle after seeing
    // the request; outputs are sampled on the falling edge and scoreboarded.
    task automatic cycle();
        floor_t exp_f;
        @(negedge clk);
        if (car_en) begin
            bus.floor = car_next;
            car_next  = (req_vec() != '0) ? decode(req_vec()) : bus.floor;
        end
        if (req_vec() != '0) saw_req = 1'b1;
        check("req_onehot", 32'($countones(req_vec()) <= 1), 32'd1);
        check("req_door_excl", 32'(req_vec() != '0 && bus.door_open), 32'd0);
        if (bus.door_open && !prev_door) begin
            if (exp_q.size() == 0) begin
                check("unexpected_stop", 32'(bus.floor), 32'hFFFF_FFFF);
            end else begin
                exp_f = exp_q.pop_front();
                check("stop_floor", 32'(bus.floor), 32'(exp_f));
                check("stop_cleared", 32'(bus.pending[bus.floor]), 32'd0);
            end
            dwell = 1;
        end else if (bus.door_open) begin
            dwell++;
        end else if (prev_door) begin
            check("dwell", 32'(dwell), 32'(exp_dwell));
        end
        prev_door = bus.door_open;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        bus.btn   = '0;
        bus.floor = FL_G;
        car_next  = FL_G;
        car_en    = 1'b1;
        prev_door = 1'b0;
        dwell     = 0;
        exp_dwell = DOOR_CYCLES;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!(exp_q.size() == 0 && !bus.busy && !bus.door_open) && n < budget) begin
            cycle();
            n++;
        end
        check({name, "_timeout"}, 32'(n < budget), 32'd1);
    endtask

    initial begin
        int n;
        n_checks = 0;
        n_pass   = 0;
        saw_req  = 1'b0;

        vecs[0] = '{start: FL_G, btn: 4'b1000, n_stops: 1, s0: FL_3, s1: FL_G, s2: FL_G, dir: 1'b1};
        vecs[1] = '{start: FL_1, btn: 4'b1101, n_stops: 3, s0: FL_2, s1: FL_3, s2: FL_G, dir: 1'b0};
        vecs[2] = '{start: FL_2, btn: 4'b0100, n_stops: 1, s0: FL_2, s1: FL_G, s2: FL_G, dir: 1'b0};
        vecs[3] = '{start: FL_2, btn: 4'b1011, n_stops: 3, s0: FL_1, s1: FL_G, s2: FL_3, dir: 1'b1};
        vecs[4] = '{start: FL_3, btn: 4'b0001, n_stops: 1, s0: FL_G, s1: FL_G, s2: FL_G, dir: 1'b0};
        vecs[5] = '{start: FL_G, btn: 4'b0110, n_stops: 2, s0: FL_1, s1: FL_2, s2: FL_G, dir: 1'b1};
        vecs[6] = '{start: FL_1, btn: 4'b0011, n_stops: 2, s0: FL_1, s1: FL_G, s2: FL_G, dir: 1'b0};

        // Reset values, request timing, then asynchronous reset mid-move.
        do_reset();
        cycle();
        check("rst_req", 32'(req_vec()), 32'd0);
        check("rst_pending", 32'(bus.pending), 32'd0);
        check("rst_door", 32'(bus.door_open), 32'd0);
        check("rst_dir", 32'(bus.dir_up), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        car_en  = 1'b0;
        bus.btn = 4'b1000;
        cycle();
        bus.btn = '0;
        check("pend_edge1", 32'(bus.pending), 32'h8);
        check("req_not_edge1", 32'(req_vec()), 32'd0);
        cycle();
        check("req_f3_edge2", 32'(bus.req_f3), 32'd1);
        check("busy_move", 32'(bus.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_req", 32'(req_vec()), 32'd0);
        check("arst_pending", 32'(bus.pending), 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_door", 32'(bus.door_open), 32'd0);
        check("arst_dir", 32'(bus.dir_up), 32'd1);

        // Table of SCAN scenarios; direction carries from one vector to the next.
        do_reset();
        for (int v = 0; v < 7; v++) begin
            cycle();
            bus.floor = vecs[v].start;
            car_next  = vecs[v].start;
            bus.btn   = vecs[v].btn;
            exp_q.push_back(vecs[v].s0);
            if (vecs[v].n_stops > 1) exp_q.push_back(vecs[v].s1);
            if (vecs[v].n_stops > 2) exp_q.push_back(vecs[v].s2);
            cycle();
            bus.btn = '0;
            wait_done($sformatf("vec%0d", v), 200);
            check($sformatf("vec%0d_dir", v), 32'(bus.dir_up), 32'(vecs[v].dir));
            check($sformatf("vec%0d_pending", v), 32'(bus.pending), 32'd0);
        end

        // Call at the current floor opens the door without any request, and a
        // press at that floor with two cycles left reopens it for a full dwell.
        do_reset();
        cycle();
        bus.floor = FL_1;
        car_next  = FL_1;
        bus.btn   = 4'b0010;
        saw_req   = 1'b0;
        exp_dwell = DOOR_CYCLES + 6;
        exp_q.push_back(FL_1);
        cycle();
        bus.btn = '0;
        n = 0;
        while (!bus.door_open && n < 20) begin cycle(); n++; end
        check("door_direct_timeout", 32'(n < 20), 32'd1);
        while (bus.door_open && dwell < 6 && n < 40) begin cycle(); n++; end
        bus.btn = 4'b0010;
        cycle();
        bus.btn = '0;
        check("reopen_pending", 32'(bus.pending[FL_1]), 32'd0);
        wait_done("reopen", 60);
        check("direct_no_req", 32'(saw_req), 32'd0);
        exp_dwell = DOOR_CYCLES;

        // New call during a move accumulates without disturbing the target.
        do_reset();
        cycle();
        car_en    = 1'b0;
        bus.floor = FL_G;
        bus.btn   = 4'b1000;
        exp_q.push_back(FL_3);
        exp_q.push_back(FL_G);
        cycle();
        bus.btn = '0;
        cycle();
        bus.floor = FL_1;
        bus.btn   = 4'b0001;
        cycle();
        bus.btn = '0;
        cycle();
        check("mid_move_pending", 32'(bus.pending), 32'h9);
        check("mid_move_req", 32'(req_vec()), 32'h8);
        check("transit_no_door", 32'(bus.door_open), 32'd0);
        bus.floor = FL_3;
        car_next  = FL_3;
        car_en    = 1'b1;
        wait_done("mid_move", 200);
        check("mid_move_dir", 32'(bus.dir_up), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
